instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
- Instruction-fetch front end of the pipelined cpu core. Holds the program counter and drives the instruction-memory address.
- Captures the returned word into the IF/ID pipeline register and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirects from downstream stages, which flush the IF/ID register.
- Stops fetching after a BREAK instruction; a halt status is exported for the core's light/status output.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- BREAK_FUNCT, 6'h0D, funct code that, with opcode 0, marks a halting instruction.

Ports:
- clock  input  1  single rising-edge clock.
- clrn  input  1  reset, asynchronous, active-low.
- imem_addr  output  32  instruction-memory byte address; equals the pc register, combinational.
- imem_rdata  input  32  instruction word; combinational read of imem_addr, valid in the same cycle.
- redirect_valid  input  1  a branch/jump has resolved taken this cycle.
- redirect_target  input  32  new PC, qualified by redirect_valid.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts the IF/ID contents this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  address of out_instr.
- out_pc4  output  32  out_pc + 4, modulo 2^32.
- halted  output  1  fetch is stopped after a BREAK.
- fetch_count  output  32  number of instructions accepted by decode, saturating.

Behaviour:
- Reset (clrn=0, takes effect immediately, no clock needed):
  - pc=RESET_PC, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, out_pc4=0, halted=0, fetch_count=0.
- States: RUN, HALT. State changes happen only on clock edges; reset is the exception.
- Load condition: load = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- On load at the clock edge:
  - out_instr<=imem_rdata, out_pc<=pc, out_pc4<=pc+4, out_valid<=1.
  - pc<=pc+4.
- No load, RUN, out_valid=1, out_ready=0 (backpressure): pc and the IF/ID register hold unchanged. The instruction is neither lost nor duplicated.
- Accepted without reload (out_valid && out_ready, but no load because state is HALT): out_valid<=0.
- Redirect (redirect_valid=1) has highest priority and overrides both load and backpressure:
  - pc<={redirect_target[31:2],2'b00}; the low two bits are silently dropped.
  - out_valid<=0. The word in IF/ID is discarded even if out_ready=1 that cycle, and it is not counted.
  - state<=RUN, halted<=0.
- BREAK detection: when the word being loaded has [31:26]==0 and [5:0]==BREAK_FUNCT:
  - It is still loaded and delivered normally.
  - state<=HALT, halted<=1 at that same edge.
- HALT state:
  - No further loads; pc holds at BREAK address + 4.
  - out_valid clears once decode accepts the BREAK word.
  - Exit only via redirect or reset.
- Latency: an instruction word appears on out_instr one clock after its address is on imem_addr. Throughput is one instruction per clock with out_ready held high.
- PC arithmetic: 32-bit, wraps modulo 2^32. A pc of 32'hFFFF_FFFC increments to 0, and out_pc4 wraps the same way.
- fetch_count: increments by 1 on each edge where out_valid && out_ready && !redirect_valid. It saturates at 32'hFFFF_FFFF.
- Simultaneous redirect and BREAK load: the redirect wins. No load occurs and the state stays or becomes RUN.
- Reset mid-operation: all state returns to reset values asynchronously. The first fetch after clrn rises is from RESET_PC at the first clock edge.

Test Plan:
- Sequential fetch: reset, memory holds 0x20080001 at 0x0 and 0x20090002 at 0x4, out_ready=1.
  - Edge 1: out_instr=0x20080001, out_pc=0, out_pc4=4.
  - Edge 2: out_instr=0x20090002, out_pc=4.
  - fetch_count=2 after edge 3.
- Backpressure: hold out_ready=0 for 3 cycles while out_pc=0x8.
  - out_instr/out_pc remain stable and imem_addr stays 0xC.
  - After release, the next out_pc is 0xC with no skip or duplicate.
- Redirect: assert redirect_valid with target 0x0000_0103 while out_valid=1.
  - The next edge gives out_valid=0 and imem_addr=0x100.
  - The following edge gives out_pc=0x100, and fetch_count is not incremented for the flushed word.
- Halt: place 0x0000000D at 0x10.
  - The BREAK word is delivered with out_pc=0x10, halted=1, pc stuck at 0x14.
  - out_valid drops after acceptance.
  - A later redirect to 0x0 clears halted and resumes fetch from 0x0.
- Wrap-around: redirect to 0xFFFF_FFFC.
  - The loaded word has out_pc=0xFFFF_FFFC and out_pc4=0.
  - The next out_pc=0x0.
- Async reset mid-stream: drop clrn between clock edges while out_valid=1 and halted=1.
  - All outputs go to their reset values immediately.
  - After release, the first out_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives instruction memory and
// holds the IF/ID register presented to decode under a valid/ready handshake.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  BREAK_FUNCT = 6'h0D
) (
    input  logic        clock,
    input  logic        clrn,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_p0;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;
    logic [31:0] count_q;
    logic        load;
    logic        accept;
    logic        is_break;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign load     = (state == RUN) && (!vld_p1 || out_ready) && !redirect_valid;
    assign accept   = vld_p1 && out_ready && !redirect_valid;
    assign is_break = (imem_rdata[31:26] == 6'd0) && (imem_rdata[5:0] == BREAK_FUNCT);

    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = RUN;
        else if (load && is_break)
            state_nxt = HALT;
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Stage p0: program counter / instruction-memory address
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn)
            pc_p0 <= RESET_PC;
        else if (redirect_valid)
            pc_p0 <= {redirect_target[31:2], 2'b00};
        else if (load)
            pc_p0 <= pc_p0 + 32'd4;
    end

    // Stage p1: IF/ID register; a redirect discards whatever it holds
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            vld_p1   <= 1'b0;
            instr_p1 <= 32'd0;
            pc_p1    <= 32'd0;
            pc4_p1   <= 32'd0;
        end else if (redirect_valid) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1   <= 1'b1;
            instr_p1 <= imem_rdata;
            pc_p1    <= pc_p0;
            pc4_p1   <= pc_p0 + 32'd4;
        end else if (accept) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn)
            count_q <= 32'd0;
        else if (accept)
            count_q <= sat_inc(count_q);
    end

    assign imem_addr   = pc_p0;
    assign out_valid   = vld_p1;
    assign out_instr   = instr_p1;
    assign out_pc      = pc_p1;
    assign out_pc4     = pc4_p1;
    assign halted      = (state == HALT);
    assign fetch_count = count_q;

endmodule
